// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix receive/transmit paths: FSM state encoding,
// default geometry and the dibit width used on the Ethernet side.
package matrix_pkg;

    localparam int DEFAULT_MAX_SIZE      = 32;
    localparam int DEFAULT_ELEMENT_WIDTH = 16;
    localparam int DIBIT_W               = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ROW = 3'd1,
        SHIFT    = 3'd2,
        CSUM     = 3'd3,
        DONE     = 3'd4
    } matrix_state_t;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Bundle of the compute-side row handshake, start/status and the dibit TX stream.
interface matrix_result_streamer_if #(
    parameter int MAX_SIZE      = 32,
    parameter int ELEMENT_WIDTH = 16
);
    // A row moves on a rising edge where row_valid && row_ready; row_data must
    // hold steady while row_valid is high and not yet accepted, and row_valid
    // may not wait on row_ready before rising.
    logic                              start;
    logic                              row_valid;
    logic [MAX_SIZE*ELEMENT_WIDTH-1:0] row_data;
    logic                              row_ready;
    logic                              axiov;
    logic [1:0]                        axiod;
    logic                              busy;
    logic                              done;
    logic                              underrun;

    modport master (
        output start, row_valid, row_data,
        input  row_ready, axiov, axiod, busy, done, underrun
    );

    modport slave (
        input  start, row_valid, row_data,
        output row_ready, axiov, axiod, busy, done, underrun
    );

endinterface

// File: rtl/dibit_serializer.sv
// Row shift register that walks one row out MSB-first, one dibit per cycle,
// flagging the final dibit of the final element.
module dibit_serializer
    import matrix_pkg::*;
#(
    parameter int MAX_SIZE      = DEFAULT_MAX_SIZE,
    parameter int ELEMENT_WIDTH = DEFAULT_ELEMENT_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [MAX_SIZE*ELEMENT_WIDTH-1:0] row_in,
    output logic [DIBIT_W-1:0]                dibit,
    output logic                              dibit_valid,
    output logic                              last_dibit
);

    localparam int ROW_W  = MAX_SIZE * ELEMENT_WIDTH;
    localparam int DPE    = ELEMENT_WIDTH / DIBIT_W;
    localparam int DCNT_W = cnt_w(DPE);
    localparam int ECNT_W = cnt_w(MAX_SIZE);
    localparam logic [DCNT_W-1:0] DIBIT_LAST = DCNT_W'(DPE - 1);
    localparam logic [ECNT_W-1:0] ELEM_LAST  = ECNT_W'(MAX_SIZE - 1);

    logic [ROW_W-1:0]  shreg;
    logic [DCNT_W-1:0] dibit_cnt;
    logic [ECNT_W-1:0] elem_cnt;

    assign dibit      = shreg[ROW_W-1 -: DIBIT_W];
    assign last_dibit = dibit_valid && (dibit_cnt == DIBIT_LAST) && (elem_cnt == ELEM_LAST);

    // A load on the final dibit wins, which keeps back-to-back rows gapless.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            dibit_valid <= 1'b0;
            dibit_cnt   <= '0;
            elem_cnt    <= '0;
        end else if (load) begin
            shreg       <= row_in;
            dibit_valid <= 1'b1;
            dibit_cnt   <= '0;
            elem_cnt    <= '0;
        end else if (dibit_valid) begin
            if (last_dibit) begin
                dibit_valid <= 1'b0;
                dibit_cnt   <= '0;
                elem_cnt    <= '0;
            end else begin
                shreg <= shreg << DIBIT_W;
                if (dibit_cnt == DIBIT_LAST) begin
                    dibit_cnt <= '0;
                    elem_cnt  <= elem_cnt + 1'b1;
                end else begin
                    dibit_cnt <= dibit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_result_streamer.sv
// Streams one result matrix per start as MSB-first dibits toward Ethernet TX.
// Define MATRIX_TX_CHECKSUM_EN to append an XOR checksum element after the last row.
module matrix_result_streamer
    import matrix_pkg::*;
#(
    parameter int MAX_SIZE      = DEFAULT_MAX_SIZE,
    parameter int ELEMENT_WIDTH = DEFAULT_ELEMENT_WIDTH
) (
    input  logic                     eth_refclk,
    input  logic                     rst,
    matrix_result_streamer_if.slave  bus,
    output matrix_state_t            fsm_state
);

    localparam int ROW_W  = MAX_SIZE * ELEMENT_WIDTH;
    localparam int RCNT_W = cnt_w(MAX_SIZE);
    localparam logic [RCNT_W-1:0] ROW_LAST = RCNT_W'(MAX_SIZE - 1);

    matrix_state_t       state;
    matrix_state_t       state_next;
    logic [RCNT_W-1:0]   row_cnt;
    logic                underrun_q;
    logic                row_ready;
    logic                handshake;
    logic                last_row;
    logic [DIBIT_W-1:0]  ser_dibit;
    logic                ser_valid;
    logic                ser_last;
    logic                csum_active;
    logic [DIBIT_W-1:0]  csum_dibit;
    logic                csum_last;

    assign handshake = bus.row_valid && row_ready;
    assign last_row  = (row_cnt == ROW_LAST);

    dibit_serializer #(
        .MAX_SIZE      (MAX_SIZE),
        .ELEMENT_WIDTH (ELEMENT_WIDTH)
    ) u_serializer (
        .clk         (eth_refclk),
        .rst         (rst),
        .load        (handshake),
        .row_in      (bus.row_data),
        .dibit       (ser_dibit),
        .dibit_valid (ser_valid),
        .last_dibit  (ser_last)
    );

    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        row_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = WAIT_ROW;
            end
            WAIT_ROW: begin
                row_ready = 1'b1;
                if (bus.row_valid) state_next = SHIFT;
            end
            SHIFT: begin
                if (ser_last) begin
                    if (last_row) begin
`ifdef MATRIX_TX_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    end else begin
                        // Offer the next row on the final dibit so it can follow with no gap.
                        row_ready  = 1'b1;
                        state_next = bus.row_valid ? SHIFT : WAIT_ROW;
                    end
                end
            end
`ifdef MATRIX_TX_CHECKSUM_EN
            CSUM: begin
                if (csum_last) state_next = DONE;
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Row counter wraps after the last row; a row ending with nothing queued marks an underrun.
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            row_cnt    <= '0;
            underrun_q <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                row_cnt    <= '0;
                underrun_q <= 1'b0;
            end
        end else if (state == SHIFT && ser_last) begin
            row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            if (!last_row && !bus.row_valid) underrun_q <= 1'b1;
        end
    end

`ifdef MATRIX_TX_CHECKSUM_EN
    localparam int DPE    = ELEMENT_WIDTH / DIBIT_W;
    localparam int CCNT_W = cnt_w(DPE);
    localparam logic [CCNT_W-1:0] CSUM_LAST = CCNT_W'(DPE - 1);

    logic [ELEMENT_WIDTH-1:0] csum_acc;
    logic [ELEMENT_WIDTH-1:0] csum_sreg;
    logic [CCNT_W-1:0]        csum_cnt;

    function automatic logic [ELEMENT_WIDTH-1:0] row_xor(input logic [ROW_W-1:0] row);
        logic [ELEMENT_WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < MAX_SIZE; i++) begin
            acc = acc ^ row[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
        return acc;
    endfunction

    // Every accepted row is transmitted in full, so folding it in at acceptance is exact.
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            csum_acc  <= '0;
            csum_sreg <= '0;
            csum_cnt  <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                csum_acc <= '0;
            end else if (handshake) begin
                csum_acc <= csum_acc ^ row_xor(bus.row_data);
            end
            if (state == SHIFT && ser_last && last_row) begin
                csum_sreg <= csum_acc;
                csum_cnt  <= '0;
            end else if (state == CSUM) begin
                csum_sreg <= csum_sreg << DIBIT_W;
                csum_cnt  <= csum_cnt + 1'b1;
            end
        end
    end

    assign csum_active = (state == CSUM);
    assign csum_dibit  = csum_sreg[ELEMENT_WIDTH-1 -: DIBIT_W];
    assign csum_last   = (csum_cnt == CSUM_LAST);
`else
    assign csum_active = 1'b0;
    assign csum_dibit  = '0;
    assign csum_last   = 1'b0;
`endif

    assign bus.row_ready = row_ready;
    assign bus.axiov     = ser_valid || csum_active;
    assign bus.axiod     = ser_valid ? ser_dibit : (csum_active ? csum_dibit : '0);
    assign bus.busy      = (state == WAIT_ROW) || (state == SHIFT) || (state == CSUM);
    assign bus.done      = (state == DONE);
    assign bus.underrun  = underrun_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer with a 2x2 matrix of 4-bit elements.
module tb_matrix_result_streamer;
    import matrix_pkg::*;

    localparam int MS  = 2;
    localparam int EW  = 4;
    localparam int RW  = MS * EW;
    localparam int DPM = MS * RW / 2;
`ifdef MATRIX_TX_CHECKSUM_EN
    localparam int CS_N = EW / 2;
`else
    localparam int CS_N = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_result_streamer_if #(.MAX_SIZE(MS), .ELEMENT_WIDTH(EW)) bus ();
    matrix_state_t fsm_state;

    matrix_result_streamer #(.MAX_SIZE(MS), .ELEMENT_WIDTH(EW)) dut (
        .eth_refclk (clk),
        .rst        (rst),
        .bus        (bus),
        .fsm_state  (fsm_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    int         cyc = 0;
    logic [1:0] got_q[$];
    int         got_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         hs_cnt = 0;
    logic       busy_at_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.axiov) begin
            got_q.push_back(bus.axiod);
            got_cyc.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = bus.busy;
        end
        if (bus.row_valid && bus.row_ready) hs_cnt++;
    end

    typedef struct {
        logic [RW-1:0] row0;
        logic [RW-1:0] row1;
        int            gap;
        bit            start_busy;
        logic [15:0]   exp_stream;
        logic [EW-1:0] exp_csum;
        bit            exp_ur;
    } vec_t;

    vec_t       vecs[6];
    logic [1:0] exp_q[$];

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_row(input logic [RW-1:0] d, input string name);
        bit ok = 1'b0;
        bus.row_valid = 1'b1;
        bus.row_data  = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.row_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.row_valid = 1'b0;
        check({name, "_hs_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   base, d0, h0, n, last, gap_seen;
        bit   ok;
        logic [1:0] g;
        v    = vecs[k];
        base = got_q.size();
        d0   = done_cnt;
        h0   = hs_cnt;
        exp_q.delete();
        for (int i = 0; i < DPM; i++) exp_q.push_back(v.exp_stream[15-2*i -: 2]);
        for (int i = 0; i < CS_N; i++) exp_q.push_back(v.exp_csum[EW-1-2*i -: 2]);

        pulse_start();
        send_row(v.row0, $sformatf("v%0d_row0", k));
        if (v.start_busy) begin
            @(negedge clk); bus.start = 1'b1;
            @(negedge clk); bus.start = 1'b0;
        end
        if (v.gap > 0) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.row_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check($sformatf("v%0d_row0_end_timeout", k), 32'(ok), 32'd1);
            @(posedge clk);
            repeat (v.gap - 1) @(posedge clk);
            #1;
        end
        send_row(v.row1, $sformatf("v%0d_row1", k));

        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("v%0d_done_timeout", k), 32'(ok), 32'd1);
        #1;

        n = got_q.size() - base;
        check($sformatf("v%0d_dibit_count", k), 32'(n), 32'(DPM + CS_N));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (base + i < got_q.size()) ? got_q[base+i] : 2'bxx;
            check($sformatf("v%0d_dibit%0d", k, i), 32'(g), 32'(exp_q[i]));
        end
        if (n > 0) begin
            last     = got_q.size() - 1;
            gap_seen = got_cyc[last] - got_cyc[base] + 1 - n;
            check($sformatf("v%0d_gap_cycles", k), 32'(gap_seen), 32'(v.gap));
            check($sformatf("v%0d_done_timing", k), 32'(done_cyc), 32'(got_cyc[last] + 1));
        end
        check($sformatf("v%0d_done_pulses", k), 32'(done_cnt - d0), 32'd1);
        check($sformatf("v%0d_busy_at_done", k), 32'(busy_at_done), 32'd0);
        check($sformatf("v%0d_handshakes", k), 32'(hs_cnt - h0), 32'd2);
        check($sformatf("v%0d_underrun", k), 32'(bus.underrun), 32'(v.exp_ur));
        @(negedge clk);
        check($sformatf("v%0d_back_to_idle", k), 32'(fsm_state), 32'(IDLE));
    endtask

    initial begin
        int base, d0, h0;
        bit ok;

        // Hand-computed: the stream is the row bits MSB-first; csum is the XOR of the four nibbles.
        vecs[0] = '{row0: 8'hA5, row1: 8'hC3, gap: 0, start_busy: 1'b0, exp_stream: 16'hA5C3, exp_csum: 4'h0, exp_ur: 1'b0};
        vecs[1] = '{row0: 8'h0F, row1: 8'h12, gap: 0, start_busy: 1'b0, exp_stream: 16'h0F12, exp_csum: 4'hC, exp_ur: 1'b0};
        vecs[2] = '{row0: 8'hA5, row1: 8'hC3, gap: 3, start_busy: 1'b0, exp_stream: 16'hA5C3, exp_csum: 4'h0, exp_ur: 1'b1};
        vecs[3] = '{row0: 8'h0F, row1: 8'h13, gap: 0, start_busy: 1'b1, exp_stream: 16'h0F13, exp_csum: 4'hD, exp_ur: 1'b0};
        vecs[4] = '{row0: 8'h00, row1: 8'hFF, gap: 1, start_busy: 1'b0, exp_stream: 16'h00FF, exp_csum: 4'h0, exp_ur: 1'b1};
        vecs[5] = '{row0: 8'h3C, row1: 8'h81, gap: 0, start_busy: 1'b0, exp_stream: 16'h3C81, exp_csum: 4'h6, exp_ur: 1'b0};

        bus.start     = 1'b0;
        bus.row_valid = 1'b0;
        bus.row_data  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_row_ready", 32'(bus.row_ready), 32'd0);
        check("rst_axiov",     32'(bus.axiov),     32'd0);
        check("rst_axiod",     32'(bus.axiod),     32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_underrun",  32'(bus.underrun),  32'd0);
        check("rst_state",     32'(fsm_state),     32'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;

        // row_valid in IDLE must not be accepted.
        h0 = hs_cnt;
        bus.row_valid = 1'b1;
        bus.row_data  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("idle_row_ready%0d", i), 32'(bus.row_ready), 32'd0);
            check($sformatf("idle_state%0d", i), 32'(fsm_state), 32'(IDLE));
        end
        @(posedge clk); #1;
        bus.row_valid = 1'b0;
        check("idle_handshakes", 32'(hs_cnt - h0), 32'd0);

        run_vec(0);
        run_vec(1);
        run_vec(2);

        // Reset on the third dibit of row 0, then a fresh matrix.
        base = got_q.size();
        d0   = done_cnt;
        pulse_start();
        send_row(8'hA5, "rstmid_row0");
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (got_q.size() >= base + 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstmid_dibit_timeout", 32'(ok), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_axiov", 32'(bus.axiov), 32'd0);
        check("rstmid_busy",  32'(bus.busy),  32'd0);
        check("rstmid_state", 32'(fsm_state), 32'(IDLE));
        repeat (4) @(negedge clk);
        #1;
        check("rstmid_no_done",  32'(done_cnt - d0), 32'd0);
        check("rstmid_underrun", 32'(bus.underrun), 32'd0);

        run_vec(3);
        run_vec(4);
        run_vec(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
